// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter with bounded burst ownership in front of a 256x8 single-port memory.
// Grant/memory port combinational from requests; read data returns one cycle after a granted read.
module mem_port_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    output logic       gnt0,
    output logic       rvalid0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       gnt1,
    output logic       rvalid1,
    output logic [7:0] rdata1,
    output logic       mem_ce,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_datai,
    input  logic [7:0] mem_datao
);

    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

    localparam logic [3:0] BURST = 4'(MAX_BURST);

    owner_t     owner;
    owner_t     winner;
    logic [3:0] cnt;
    logic       last;
    logic       rv0_q;
    logic       rv1_q;
    logic       below;

    assign below = (cnt < BURST);

    // Owner keeps the port until its burst budget is spent while the other side waits.
    always_comb begin
        winner = OWN_NONE;
        if (owner == OWN_M0 && req0 && (below || !req1))
            winner = OWN_M0;
        else if (owner == OWN_M1 && req1 && (below || !req0))
            winner = OWN_M1;
        else if (req0 && !req1)
            winner = OWN_M0;
        else if (req1 && !req0)
            winner = OWN_M1;
        else if (req0 && req1)
            winner = last ? OWN_M0 : OWN_M1;
        if (reset)
            winner = OWN_NONE;
    end

    assign gnt0   = (winner == OWN_M0);
    assign gnt1   = (winner == OWN_M1);
    assign mem_ce = (winner != OWN_NONE);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 8'h00;
        mem_datai = 8'h00;
        case (winner)
            OWN_M0: begin
                mem_we    = we0;
                mem_addr  = addr0;
                mem_datai = wdata0;
            end
            OWN_M1: begin
                mem_we    = we1;
                mem_addr  = addr1;
                mem_datai = wdata1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_NONE;
            cnt   <= 4'd0;
            last  <= 1'b1;
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            rv0_q <= gnt0 & ~we0;
            rv1_q <= gnt1 & ~we1;
            if (winner == OWN_NONE) begin
                owner <= OWN_NONE;
                cnt   <= 4'd0;
            end else if (winner != owner) begin
                owner <= winner;
                cnt   <= 4'd1;
                last  <= (winner == OWN_M1);
            end else if (below) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // A read still in flight when reset arrives is dropped, not returned.
    assign rvalid0 = rv0_q & ~reset;
    assign rvalid1 = rv1_q & ~reset;
    assign rdata0  = rvalid0 ? mem_datao : 8'h00;
    assign rdata1  = rvalid1 ? mem_datao : 8'h00;

endmodule
